read_data: RTL and testbench

READ_DATA -- requirements
Module: read_data

---
 rtl/read_data.sv | 217 +++++++++++++++++++++
 tb/tb_read_data.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/read_data.sv
// read_data: walks a pixel-pair memory one row at a time, emitting a frame-start pulse,
// per-row blanking and registered pixel pairs. Define BMP_ROW_FLIP_EN to read rows bottom-up.
module read_data #(
    parameter int IMAGE_WIDTH   = 768,
    parameter int IMAGE_HEIGHT  = 512,
    parameter int ADDR_WIDTH    = 18,
    parameter int VSYNC_CYCLES  = 4,
    parameter int HBLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_Address,
    output logic                  mem_Read_Enable,
    input  logic [47:0]           mem_Data,
    output logic                  vertical_Pulse,
    output logic                  horizontal_Pulse,
    output logic [7:0]            data_Red_Even,
    output logic [7:0]            data_Green_Even,
    output logic [7:0]            data_Blue_Even,
    output logic [7:0]            data_Red_Odd,
    output logic [7:0]            data_Green_Odd,
    output logic [7:0]            data_Blue_Odd,
    output logic                  busy,
    output logic                  sig_Read_Done
);

    localparam int PAIRS   = IMAGE_WIDTH / 2;
    localparam int CNT_MAX = (VSYNC_CYCLES > HBLANK_CYCLES) ? VSYNC_CYCLES : HBLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PAIR_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ROW_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [CNT_W-1:0]  VSYNC_LAST  = CNT_W'(VSYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HBLANK_LAST = CNT_W'(HBLANK_CYCLES - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST   = PAIR_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMAGE_HEIGHT - 1);

`ifdef BMP_ROW_FLIP_EN
    localparam logic [ADDR_WIDTH-1:0] FIRST_BASE = ADDR_WIDTH'((IMAGE_HEIGHT - 1) * PAIRS);
`else
    localparam logic [ADDR_WIDTH-1:0] FIRST_BASE = {ADDR_WIDTH{1'b0}};
`endif

    // Row base address of the row that follows the current one in read order.
    function automatic logic [ADDR_WIDTH-1:0] next_base(input logic [ADDR_WIDTH-1:0] base);
`ifdef BMP_ROW_FLIP_EN
        return base - ADDR_WIDTH'(PAIRS);
`else
        return base + ADDR_WIDTH'(PAIRS);
`endif
    endfunction

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VSYNC    = 3'd1,
        HBLANK   = 3'd2,
        READ_ROW = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [PAIR_W-1:0]     pair_r, pair_s;
    logic [ROW_W-1:0]      row_r, row_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic                  accept_s;
    logic                  last_rd_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  read_en_r;
    logic                  vpulse_r;
    logic                  vld_d1_r;
    logic                  last_d1_r;
    logic                  last_d2_r;
    logic                  hpulse_r;
    logic [47:0]           pix_r;
    logic                  busy_r;
    logic                  done_r;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pair_r  <= {PAIR_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            base_r  <= FIRST_BASE;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pair_r  <= pair_s;
            row_r   <= row_s;
            base_r  <= base_s;
        end
    end

    // Next-state and counter logic; start only counts when no frame is in flight.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pair_s    = pair_r;
        row_s     = row_r;
        base_s    = base_r;
        accept_s  = 1'b0;
        last_rd_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !busy_r) begin
                    state_s  = VSYNC;
                    cnt_s    = {CNT_W{1'b0}};
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            VSYNC: begin
                if (cnt_r == VSYNC_LAST) begin
                    state_s = HBLANK;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            HBLANK: begin
                if (cnt_r == HBLANK_LAST) begin
                    state_s = READ_ROW;
                    cnt_s   = {CNT_W{1'b0}};
                    pair_s  = {PAIR_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            READ_ROW: begin
                if (pair_r == PAIR_LAST) begin
                    pair_s = {PAIR_W{1'b0}};
                    if (row_r == ROW_LAST) begin
                        state_s   = DONE;
                        last_rd_s = 1'b1;
                    end else begin
                        state_s = HBLANK;
                        row_s   = row_r + ROW_W'(1);
                        base_s  = next_base(base_r);
                    end
                end else begin
                    pair_s = pair_r + PAIR_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                pair_s  = {PAIR_W{1'b0}};
                row_s   = {ROW_W{1'b0}};
                base_s  = FIRST_BASE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                pair_s  = {PAIR_W{1'b0}};
                row_s   = {ROW_W{1'b0}};
                base_s  = FIRST_BASE;
            end
        endcase
    end

    // Registered outputs: strobe/address track the next state so they line up with READ_ROW;
    // the data path trails the strobe by the memory latency plus one capture stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r    <= {ADDR_WIDTH{1'b0}};
            read_en_r <= 1'b0;
            vpulse_r  <= 1'b0;
            vld_d1_r  <= 1'b0;
            last_d1_r <= 1'b0;
            last_d2_r <= 1'b0;
            hpulse_r  <= 1'b0;
            pix_r     <= 48'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            vpulse_r  <= (state_s == VSYNC);
            read_en_r <= (state_s == READ_ROW);
            if (state_s == READ_ROW) begin
                addr_r <= base_s + ADDR_WIDTH'(pair_s);
            end else begin
                addr_r <= addr_r;
            end
            vld_d1_r  <= read_en_r;
            last_d1_r <= last_rd_s;
            last_d2_r <= last_d1_r;
            hpulse_r  <= vld_d1_r;
            pix_r     <= vld_d1_r ? mem_Data : 48'd0;
            done_r    <= last_d2_r;
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (last_d2_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign mem_Address      = addr_r;
    assign mem_Read_Enable  = read_en_r;
    assign vertical_Pulse   = vpulse_r;
    assign horizontal_Pulse = hpulse_r;
    assign data_Red_Even    = pix_r[47:40];
    assign data_Green_Even  = pix_r[39:32];
    assign data_Blue_Even   = pix_r[31:24];
    assign data_Red_Odd     = pix_r[23:16];
    assign data_Green_Odd   = pix_r[15:8];
    assign data_Blue_Odd    = pix_r[7:0];
    assign busy             = busy_r;
    assign sig_Read_Done    = done_r;

endmodule

// File: tb/tb_read_data.sv
// Bench for read_data on a 4x2 image: per-cycle control table, address/data scoreboard,
// plus mid-row reset and back-to-back frame sequences.
module tb_read_data;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int AW    = 18;
    localparam int VS    = 2;
    localparam int HB    = 3;
    localparam int PAIRS = W / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] mem_Address;
    logic          mem_Read_Enable;
    logic [47:0]   mem_Data = 48'd0;
    logic          vertical_Pulse, horizontal_Pulse, busy, sig_Read_Done;
    logic [7:0]    data_Red_Even, data_Green_Even, data_Blue_Even;
    logic [7:0]    data_Red_Odd, data_Green_Odd, data_Blue_Odd;
    logic [47:0]   pix;

    int            n_vec = 0;
    int            n_err = 0;
    int            sb_addr[$];
    int            sb_data[$];
    logic [AW-1:0] last_addr = '0;
    int            exp_a;
    int            exp_d;
    logic [7:0]    exp_b;

    typedef struct {
        logic       start;
        logic [4:0] exp;   // {vertical, horizontal, read_enable, busy, done}
    } vec_t;
    vec_t tbl[16];

    read_data #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_WIDTH(AW),
        .VSYNC_CYCLES(VS), .HBLANK_CYCLES(HB)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_Address(mem_Address), .mem_Read_Enable(mem_Read_Enable), .mem_Data(mem_Data),
        .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
        .data_Red_Even(data_Red_Even), .data_Green_Even(data_Green_Even),
        .data_Blue_Even(data_Blue_Even), .data_Red_Odd(data_Red_Odd),
        .data_Green_Odd(data_Green_Odd), .data_Blue_Odd(data_Blue_Odd),
        .busy(busy), .sig_Read_Done(sig_Read_Done)
    );

    always #5 clk = ~clk;

    assign pix = {data_Red_Even, data_Green_Even, data_Blue_Even,
                  data_Red_Odd, data_Green_Odd, data_Blue_Odd};

    // Memory model: word n holds n in every byte, returned the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_Read_Enable) mem_Data <= {6{mem_Address[7:0]}};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < H; r++) begin
`ifdef BMP_ROW_FLIP_EN
            int row = H - 1 - r;
`else
            int row = r;
`endif
            for (int p = 0; p < PAIRS; p++) begin
                sb_addr.push_back(row * PAIRS + p);
                sb_data.push_back(row * PAIRS + p);
            end
        end
    endtask

    // which: 0 waits for sig_Read_Done, 1 for horizontal_Pulse
    task automatic wait_for(input int which, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (which == 0) ? (sig_Read_Done === 1'b1) : (horizontal_Pulse === 1'b1);
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    // Scoreboard monitor: addresses and pixel pairs against the expected queues.
    always @(negedge clk) begin
        if (mem_Read_Enable === 1'b1) begin
            if (sb_addr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL addr_extra: read of %0d with none expected", mem_Address);
            end else begin
                exp_a = sb_addr.pop_front();
                check("addr", 64'(mem_Address), 64'(exp_a));
                last_addr = AW'(exp_a);
            end
        end else begin
            check("addr_hold", 64'(mem_Address), 64'(last_addr));
        end
        if (horizontal_Pulse === 1'b1) begin
            if (sb_data.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pair_extra: pair %0h with none expected", pix);
            end else begin
                exp_d = sb_data.pop_front();
                exp_b = 8'(exp_d);
                check("pair_data", 64'(pix), 64'({6{exp_b}}));
            end
        end else begin
            check("idle_data", 64'(pix), 64'd0);
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 5'b10010};
        tbl[1]  = '{1'b0, 5'b10010};
        tbl[2]  = '{1'b0, 5'b00010};
        tbl[3]  = '{1'b0, 5'b00010};
        tbl[4]  = '{1'b0, 5'b00010};
        tbl[5]  = '{1'b0, 5'b00110};
        tbl[6]  = '{1'b0, 5'b00110};
        tbl[7]  = '{1'b0, 5'b01010};
        tbl[8]  = '{1'b0, 5'b01010};
        tbl[9]  = '{1'b0, 5'b00010};
        tbl[10] = '{1'b0, 5'b00110};
        tbl[11] = '{1'b1, 5'b00110};   // start re-pulsed mid-row: must be ignored
        tbl[12] = '{1'b0, 5'b01010};
        tbl[13] = '{1'b0, 5'b01010};
        tbl[14] = '{1'b0, 5'b00001};
        tbl[15] = '{1'b0, 5'b00000};

        #12;
        check("reset_ctrl", 64'({mem_Address, mem_Read_Enable, vertical_Pulse,
                                 horizontal_Pulse, busy, sig_Read_Done}), 64'd0);
        check("reset_data", 64'(pix), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", 64'({vertical_Pulse, mem_Read_Enable, busy, sig_Read_Done}), 64'd0);
        end

        push_frame();
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("ctrl_cycle%0d", i),
                  64'({vertical_Pulse, horizontal_Pulse, mem_Read_Enable, busy, sig_Read_Done}),
                  64'(tbl[i].exp));
        end
        start = 1'b0;
        check("frame_items_left", 64'(sb_addr.size() + sb_data.size()), 64'd0);

        // Reset asserted while a row is being presented.
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(1, 40, "row_start");
        #2 reset = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({mem_Address, mem_Read_Enable, vertical_Pulse,
                                       horizontal_Pulse, busy, sig_Read_Done}), 64'd0);
        check("async_reset_data", 64'(pix), 64'd0);
        sb_addr.delete();
        sb_data.delete();
        last_addr = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_no_start", 64'({vertical_Pulse, horizontal_Pulse, mem_Read_Enable,
                                        busy, sig_Read_Done}), 64'd0);
        end
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(0, 60, "frame_after_reset");
        check("after_reset_items_left", 64'(sb_addr.size() + sb_data.size()), 64'd0);

        // start held high: the next frame opens with VSYNC right after the done pulse.
        push_frame();
        push_frame();
        start = 1'b1;
        wait_for(0, 60, "b2b_first_done");
        check("b2b_busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("b2b_vsync_next", 64'({vertical_Pulse, busy}), 64'd3);
        start = 1'b0;
        wait_for(0, 60, "b2b_second_done");
        check("b2b_items_left", 64'(sb_addr.size() + sb_data.size()), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_stopped", 64'({vertical_Pulse, busy, sig_Read_Done}), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
